// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared constants for the UART command controller: opcodes, the error
// response byte, FSM state encoding and a small sizing helper.
package sys_cmd_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
   localparam logic [7:0] ERR_CODE    = 8'hEE;

   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_GET_ADDR = 4'd1;
   localparam logic [3:0] ST_GET_DATA = 4'd2;
   localparam logic [3:0] ST_RF_WR    = 4'd3;
   localparam logic [3:0] ST_RF_RD    = 4'd4;
   localparam logic [3:0] ST_RD_WAIT  = 4'd5;
   localparam logic [3:0] ST_GET_A    = 4'd6;
   localparam logic [3:0] ST_GET_B    = 4'd7;
   localparam logic [3:0] ST_GET_FUN  = 4'd8;
   localparam logic [3:0] ST_ALU_RUN  = 4'd9;
   localparam logic [3:0] ST_TX       = 4'd10;
   localparam logic [3:0] ST_ERR      = 4'd11;

   typedef enum logic [3:0] {
      S_IDLE     = ST_IDLE,
      S_GET_ADDR = ST_GET_ADDR,
      S_GET_DATA = ST_GET_DATA,
      S_RF_WR    = ST_RF_WR,
      S_RF_RD    = ST_RF_RD,
      S_RD_WAIT  = ST_RD_WAIT,
      S_GET_A    = ST_GET_A,
      S_GET_B    = ST_GET_B,
      S_GET_FUN  = ST_GET_FUN,
      S_ALU_RUN  = ST_ALU_RUN,
      S_TX       = ST_TX,
      S_ERR      = ST_ERR
   } state_t;

   // Number of DATA_W-sized bytes needed to carry a W-bit value
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/sys_cmd_tx_ser.sv
// Response serialiser: loads up to NBYTES bytes plus a byte count and
// pushes them to the TX FIFO LSB first, stalling while tx_full is high.
module sys_cmd_tx_ser #(
   parameter int DATA_W = 8,
   parameter int NBYTES = 2,
   parameter int CNT_W  = $clog2(NBYTES + 1)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     load,
   input  logic [NBYTES*DATA_W-1:0] load_data,
   input  logic [CNT_W-1:0]         load_cnt,
   input  logic                     tx_full,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_valid,
   output logic                     done
);

   logic [NBYTES*DATA_W-1:0] shreg;
   logic [CNT_W-1:0]         remain;
   logic                     send;

   assign send = !load && (remain != '0) && !tx_full;

   // Byte shift register; content is meaningless until loaded
   always_ff @(posedge CLK) begin
      if (load)
         shreg <= load_data;
      else if (send)
         shreg <= shreg >> DATA_W;
   end

   // Byte counter and registered TX strobe; tx_data holds across stalls
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         remain   <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         done     <= 1'b0;
         if (load) begin
            remain <= load_cnt;
         end else if (send) begin
            tx_data  <= shreg[DATA_W-1:0];
            tx_valid <= 1'b1;
            remain   <= remain - 1'b1;
            done     <= (remain == CNT_W'(1));
         end
      end
   end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command controller between UART RX, register file, ALU and TX FIFO.
// Parses AA/BB/CC/DD frames, drives RF and ALU, returns responses LSB first.
// Optional inter-byte frame timeout: define SYS_CMD_TIMEOUT_EN.
module sys_cmd_ctrl
   import sys_cmd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int ALU_OUT_W   = 16,
   parameter int OPA_ADDR    = 0,
   parameter int OPB_ADDR    = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_W-1:0]    rx_data,
   input  logic                 rx_valid,
   input  logic [DATA_W-1:0]    rd_data,
   input  logic                 rd_valid,
   input  logic [ALU_OUT_W-1:0] alu_out,
   input  logic                 alu_valid,
   input  logic                 tx_full,
   output logic [ADDR_W-1:0]    rf_addr,
   output logic                 rf_wr_en,
   output logic                 rf_rd_en,
   output logic [DATA_W-1:0]    rf_wr_data,
   output logic                 alu_en,
   output logic [3:0]           alu_fun,
   output logic                 alu_clk_en,
   output logic [DATA_W-1:0]    tx_data,
   output logic                 tx_valid,
   output logic                 busy,
   output logic                 err
);

   localparam int NBYTES = ceil_div(ALU_OUT_W, DATA_W);
   localparam int CNT_W  = $clog2(NBYTES + 1);
   localparam int RESP_W = NBYTES * DATA_W;

   state_t             state, next;
   logic               is_rd;
   logic               ser_load, ser_done;
   logic [CNT_W-1:0]   ser_cnt;
   logic [RESP_W-1:0]  resp;
   logic               timeout_hit;

`ifdef SYS_CMD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
   logic            in_wait;

   assign in_wait = state inside {S_GET_ADDR, S_GET_DATA, S_GET_A, S_GET_B, S_GET_FUN};

   // Inter-byte counter, restarted by every received byte
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         to_cnt <= '0;
      else if (!in_wait || rx_valid)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout_hit = in_wait && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   // Frame states wait forever; TIMEOUT_CYC has no effect in this build
   assign timeout_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= next;
   end

   // Next-state decode and response loading into the serialiser
   always_comb begin
      next     = state;
      ser_load = 1'b0;
      ser_cnt  = CNT_W'(1);
      resp     = '0;
      case (state)
         S_IDLE: if (rx_valid) begin
            if (rx_data == DATA_W'(CMD_RF_WR) || rx_data == DATA_W'(CMD_RF_RD)) next = S_GET_ADDR;
            else if (rx_data == DATA_W'(CMD_ALU_OP))                           next = S_GET_A;
            else if (rx_data == DATA_W'(CMD_ALU_NOP))                          next = S_GET_FUN;
            else                                                               next = S_ERR;
         end
         S_GET_ADDR: if (rx_valid) next = is_rd ? S_RF_RD : S_GET_DATA;
         S_GET_DATA: if (rx_valid) next = S_RF_WR;
         S_RF_WR:    next = S_IDLE;
         S_RF_RD:    next = S_RD_WAIT;
         S_RD_WAIT: if (rd_valid) begin
            resp[DATA_W-1:0] = rd_data;
            ser_load         = 1'b1;
            next             = S_TX;
         end
         S_GET_A:    if (rx_valid) next = S_GET_B;
         S_GET_B:    if (rx_valid) next = S_GET_FUN;
         S_GET_FUN:  if (rx_valid) next = S_ALU_RUN;
         S_ALU_RUN: if (alu_valid) begin
            resp[ALU_OUT_W-1:0] = alu_out;
            ser_cnt             = CNT_W'(NBYTES);
            ser_load            = 1'b1;
            next                = S_TX;
         end
         S_TX:       if (ser_done) next = S_IDLE;
         S_ERR: begin
            resp[DATA_W-1:0] = DATA_W'(ERR_CODE);
            ser_load         = 1'b1;
            next             = S_TX;
         end
         default:    next = S_IDLE;
      endcase
      if (timeout_hit) next = S_IDLE;
   end

   // Registered RF/ALU/status outputs derived from the upcoming state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         is_rd      <= 1'b0;
         rf_addr    <= '0;
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         rf_wr_data <= '0;
         alu_en     <= 1'b0;
         alu_fun    <= '0;
         alu_clk_en <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         busy       <= (next != S_IDLE);
         rf_rd_en   <= (next == S_RF_RD);
         alu_en     <= (next == S_ALU_RUN);
         alu_clk_en <= (next == S_ALU_RUN);
         err        <= (next == S_ERR) || timeout_hit;
         rf_wr_en   <= (next == S_RF_WR) ||
                       (rx_valid && (state == S_GET_A || state == S_GET_B));
         if (rx_valid) begin
            case (state)
               S_IDLE:     is_rd <= (rx_data == DATA_W'(CMD_RF_RD));
               S_GET_ADDR: rf_addr <= rx_data[ADDR_W-1:0];
               S_GET_DATA: rf_wr_data <= rx_data;
               S_GET_A: begin
                  rf_addr    <= ADDR_W'(OPA_ADDR);
                  rf_wr_data <= rx_data;
               end
               S_GET_B: begin
                  rf_addr    <= ADDR_W'(OPB_ADDR);
                  rf_wr_data <= rx_data;
               end
               S_GET_FUN:  alu_fun <= rx_data[3:0];
               default:    ;
            endcase
         end
      end
   end

   sys_cmd_tx_ser #(
      .DATA_W (DATA_W),
      .NBYTES (NBYTES),
      .CNT_W  (CNT_W)
   ) u_tx_ser (
      .CLK       (CLK),
      .RST       (RST),
      .load      (ser_load),
      .load_data (resp),
      .load_cnt  (ser_cnt),
      .tx_full   (tx_full),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: RF and ALU environment models, a frame-level
// reference model, directed frames followed by randomized frames.
module tb_sys_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rd_data = '0;
   logic        rd_valid = 1'b0;
   logic [15:0] alu_out = '0;
   logic        alu_valid = 1'b0;
   logic        tx_full = 1'b0;
   logic [3:0]  rf_addr;
   logic        rf_wr_en, rf_rd_en;
   logic [7:0]  rf_wr_data;
   logic        alu_en;
   logic [3:0]  alu_fun;
   logic        alu_clk_en;
   logic [7:0]  tx_data;
   logic        tx_valid, busy, err;

`ifdef SYS_CMD_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 1024;
`endif

   sys_cmd_ctrl #(
      .DATA_W(8), .ADDR_W(4), .ALU_OUT_W(16), .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
      .rd_data(rd_data), .rd_valid(rd_valid), .alu_out(alu_out), .alu_valid(alu_valid),
      .tx_full(tx_full), .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
      .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun), .alu_clk_en(alu_clk_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .err(err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   wire [30:0] all_out = {rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_en, alu_fun,
                          alu_clk_en, tx_data, tx_valid, busy, err};

   logic [7:0]  env_mem [16];
   logic [7:0]  ref_mem [16];
   logic [7:0]  frame_q [$];
   logic [7:0]  exp_tx [$], obs_tx [$];
   logic [11:0] exp_wr [$], obs_wr [$];
   int exp_err, obs_err, first_tx_cyc, last_drive_cyc, lat_base;
   int n_checks = 0, n_err = 0;
   int rd_lat = 0, alu_lat = 0, full_mode = 0, full_ph = 0;
   logic [3:0] rd_a;
   logic [7:0] bad;

   // ALU behaviour of the environment (function codes 0..2 defined, rest mixed)
   function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return {a, b};
         4'd2:    return 16'(a) * 16'(b);
         default: return {f, 4'h0, a ^ b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Frame-level reference: expected RF writes, TX bytes and error pulses
   task automatic model_frame();
      logic [15:0] r;
      logic [3:0]  a;
      exp_tx.delete(); exp_wr.delete(); exp_err = 0;
      case (frame_q[0])
         8'hAA: begin
            a = frame_q[1][3:0];
            exp_wr.push_back({a, frame_q[2]});
            ref_mem[a] = frame_q[2];
         end
         8'hBB: exp_tx.push_back(ref_mem[frame_q[1][3:0]]);
         8'hCC: begin
            exp_wr.push_back({4'd0, frame_q[1]});
            exp_wr.push_back({4'd1, frame_q[2]});
            ref_mem[0] = frame_q[1];
            ref_mem[1] = frame_q[2];
            r = alu_f(frame_q[1], frame_q[2], frame_q[3][3:0]);
            exp_tx.push_back(r[7:0]);
            exp_tx.push_back(r[15:8]);
         end
         8'hDD: begin
            r = alu_f(ref_mem[0], ref_mem[1], frame_q[1][3:0]);
            exp_tx.push_back(r[7:0]);
            exp_tx.push_back(r[15:8]);
         end
         default: begin
            exp_err = 1;
            exp_tx.push_back(8'hEE);
         end
      endcase
   endtask

   // Monitor: collects TX bytes, RF writes and err cycles; RF model storage
   initial forever begin
      @(negedge CLK);
      if (tx_valid) begin
         obs_tx.push_back(tx_data);
         if (first_tx_cyc < 0) first_tx_cyc = cyc;
      end
      if (rf_wr_en) begin
         obs_wr.push_back({rf_addr, rf_wr_data});
         env_mem[rf_addr] = rf_wr_data;
      end
      if (err) obs_err++;
   end

   // RF read responder
   initial forever begin
      @(negedge CLK);
      if (rf_rd_en) begin
         rd_a = rf_addr;
         repeat (1 + rd_lat) @(negedge CLK);
         rd_data  = env_mem[rd_a];
         rd_valid = 1'b1;
         @(negedge CLK);
         rd_valid = 1'b0;
         rd_data  = 8'($urandom);
      end
   end

   // ALU responder
   initial forever begin
      @(negedge CLK);
      if (alu_en) begin
         repeat (alu_lat) @(negedge CLK);
         alu_out   = alu_f(env_mem[0], env_mem[1], alu_fun);
         alu_valid = 1'b1;
         @(negedge CLK);
         alu_valid = 1'b0;
         alu_out   = 16'($urandom);
         while (alu_en) @(negedge CLK);
      end
   end

   // TX FIFO full generator
   initial forever begin
      @(negedge CLK);
      case (full_mode)
         1: tx_full = ($urandom_range(0, 2) == 0);
         2: begin
            tx_full = (full_ph < 5);
            full_ph = (full_ph + 1) % 6;
         end
         3: tx_full = 1'b1;
         default: tx_full = 1'b0;
      endcase
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      rx_data        = b;
      rx_valid       = 1'b1;
      last_drive_cyc = cyc;
      @(negedge CLK);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic run_frame(input bit gaps, input bit poke);
      int k;
      logic [7:0] op;
      model_frame();
      obs_tx.delete(); obs_wr.delete(); obs_err = 0; first_tx_cyc = -1;
      op = frame_q[0];
      foreach (frame_q[i]) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
         send_byte(frame_q[i]);
      end
      lat_base = last_drive_cyc + 1;
      if (op == 8'hCC || op == 8'hDD) chk("alu_en_lat", 32'(alu_en), 1);
      if (poke) begin
         repeat (3) @(negedge CLK);
         if (busy) send_byte(8'h55);
      end
      k = 0;
      while (busy !== 1'b0 && k < 400) begin
         @(negedge CLK);
         k++;
      end
      chk("busy_drop", 32'(busy), 0);
      repeat (3) @(negedge CLK);
      chk("tx_len", obs_tx.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
         chk("tx_byte", 32'(obs_tx[i]), 32'(exp_tx[i]));
      chk("wr_len", obs_wr.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         chk("rf_write", 32'(obs_wr[i]), 32'(exp_wr[i]));
      chk("err_cycles", obs_err, exp_err);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      repeat (3) @(negedge CLK);
      chk("reset_outputs", 32'(all_out), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_outputs", 32'(all_out), 0);

      // RF write: no response
      frame_q = '{8'hAA, 8'h05, 8'h3C};
      run_frame(0, 0);

      // RF read with two extra cycles of read latency
      rd_lat = 2;
      frame_q = '{8'hBB, 8'h05};
      run_frame(0, 0);
      chk("rd_latency", first_tx_cyc - lat_base, 3 + rd_lat);

      // ALU with operands
      rd_lat = 0; alu_lat = 1;
      frame_q = '{8'hCC, 8'h10, 8'h20, 8'h00};
      run_frame(0, 0);
      chk("alu_fun", 32'(alu_fun), 0);

      // Same frame under heavy back-pressure; a stray byte while busy is ignored
      full_mode = 2; full_ph = 0;
      frame_q = '{8'hCC, 8'h10, 8'h20, 8'h00};
      run_frame(0, 1);
      full_mode = 0;

      // Unknown opcode
      frame_q = '{8'h55};
      run_frame(0, 0);

      // ALU without operands reuses stored operands
      frame_q = '{8'hDD, 8'h02};
      run_frame(0, 0);

      // Randomized frames with gaps, latencies and back-pressure
      full_mode = 1;
      for (int t = 0; t < 40; t++) begin
         rd_lat  = $urandom_range(0, 3);
         alu_lat = $urandom_range(0, 3);
         frame_q.delete();
         case ($urandom_range(0, 4))
            0: frame_q = '{8'hAA, 8'($urandom), 8'($urandom)};
            1: frame_q = '{8'hBB, 8'($urandom)};
            2: frame_q = '{8'hCC, 8'($urandom), 8'($urandom), 8'($urandom)};
            3: frame_q = '{8'hDD, 8'($urandom)};
            default: begin
               bad = 8'($urandom);
               while (bad inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) bad = 8'($urandom);
               frame_q = '{bad};
            end
         endcase
         run_frame(1, 0);
      end
      full_mode = 0;
      repeat (2) @(negedge CLK);

      // Reset mid-frame
      obs_tx.delete(); obs_wr.delete(); obs_err = 0;
      send_byte(8'hAA);
      send_byte(8'h05);
      RST = 1'b0;
      #1 chk("rst_midframe", 32'(all_out), 0);
      repeat (3) @(negedge CLK);
      chk("rst_held", 32'(all_out), 0);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_frame_wr", obs_wr.size(), 0);

      // Reset mid-TX: response stuck behind a full FIFO is abandoned
      full_mode = 3;
      alu_lat = 0;
      frame_q = '{8'hCC, 8'h11, 8'h22, 8'h03};
      model_frame();
      obs_tx.delete(); obs_wr.delete(); obs_err = 0;
      foreach (frame_q[i]) send_byte(frame_q[i]);
      repeat (10) @(negedge CLK);
      chk("stall_no_tx", obs_tx.size(), 0);
      chk("stall_wr_len", obs_wr.size(), 2);
      RST = 1'b0;
      #1 chk("rst_midtx", 32'(all_out), 0);
      full_mode = 0;
      repeat (5) @(negedge CLK);
      RST = 1'b1;
      repeat (5) @(negedge CLK);
      chk("rst_tx_aborted", obs_tx.size(), 0);

      // Operands written before the reset are still readable
      frame_q = '{8'hBB, 8'h01};
      run_frame(0, 0);

`ifdef SYS_CMD_TIMEOUT_EN
      // Incomplete frame times out with an err pulse and no response
      obs_tx.delete(); obs_wr.delete(); obs_err = 0;
      send_byte(8'hAA);
      send_byte(8'h05);
      k = 0;
      while (err !== 1'b1 && k < 40) begin
         @(negedge CLK);
         k++;
      end
      chk("timeout_latency", cyc - (last_drive_cyc + 1), TO_CYC);
      repeat (3) @(negedge CLK);
      chk("timeout_idle", 32'(busy), 0);
      chk("timeout_no_wr", obs_wr.size(), 0);
      chk("timeout_no_tx", obs_tx.size(), 0);
      chk("timeout_err_cycles", obs_err, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
